// File: rtl/ysyx_22050019_prefetch_buffer.sv
// ysyx_22050019_prefetch_buffer: sequential-line instruction prefetch FIFO between IFU and I-cache.
// Serves hits combinationally, bypasses the first beat into an empty FIFO, and drops stale lines on redirect.
`default_nettype none

module ysyx_22050019_prefetch_buffer #(
  parameter int          LINE_W   = 128,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ar_ready_i,
  output logic              ar_valid_o,
  output logic [31:0]       ar_addr_o,
  input  logic              r_valid_i,
  input  logic [LINE_W-1:0] r_data_i,
  input  logic [1:0]        r_resp_i,
  output logic              r_ready_o,
  input  logic              flush_i,
  input  logic [31:0]       flush_pc_i,
  input  logic [31:0]       pc_i,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic              inst_err_o
);

  localparam int OFF   = $clog2(LINE_W / 8);
  localparam int TAG_W = 32 - OFF;
  localparam int PW    = $clog2(DEPTH);
  localparam int BIT_W = $clog2(LINE_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_t;

  state_t            state;
  logic              drop;
  logic [TAG_W-1:0]  fetch_tag;
  logic [PW:0]       rd_ptr;
  logic [PW:0]       wr_ptr;
  logic [PW:0]       count;

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [LINE_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  err_mem;

  logic [PW-1:0]     head_idx;
  logic [PW-1:0]     next_idx;
  logic [PW-1:0]     wr_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic [TAG_W-1:0]  req_tag;
  logic [TAG_W-1:0]  target_tag;
  logic              empty;
  logic              head_hit;
  logic              next_hit;
  logic              miss;
  logic              redirect;
  logic              beat;
  logic              push;
  logic              pop;
  logic              bypass;
  logic [LINE_W-1:0] sel_line;
  logic              sel_err;
  logic [BIT_W-1:0]  bit_base;
  logic              unused_bits;

  assign head_idx   = rd_ptr[PW-1:0];
  assign next_idx   = head_idx + PW'(1);
  assign wr_idx     = wr_ptr[PW-1:0];
  assign count      = wr_ptr - rd_ptr;
  assign empty      = (count == '0);
  assign pc_tag     = pc_i[31:OFF];
  assign req_tag    = ar_addr_o[31:OFF];
  assign target_tag = flush_i ? flush_pc_i[31:OFF] : pc_tag;

  assign head_hit = !empty && (tag_mem[head_idx] == pc_tag);
  assign next_hit = (count > (PW+1)'(1)) && !head_hit && (tag_mem[next_idx] == pc_tag);
  // A non-empty FIFO that cannot serve pc_i behaves exactly like a redirect to pc_i.
  assign miss     = !empty && !head_hit && !next_hit;
  assign redirect = flush_i || miss;

  assign beat   = (state == S_R) && r_valid_i;
  assign push   = beat && !drop && !redirect;
  assign pop    = next_hit && !flush_i;
  assign bypass = empty && beat && !drop && !flush_i && (req_tag == pc_tag);

  always_comb begin
    sel_line = data_mem[head_idx];
    sel_err  = err_mem[head_idx];
    if (bypass) begin
      sel_line = r_data_i;
      sel_err  = |r_resp_i;
    end else if (next_hit) begin
      sel_line = data_mem[next_idx];
      sel_err  = err_mem[next_idx];
    end
  end

  assign bit_base     = {pc_i[OFF-1:2], 5'd0};
  assign inst_o       = sel_line[bit_base +: 32];
  assign inst_err_o   = sel_err;
  assign inst_valid_o = !flush_i && (head_hit || next_hit || bypass);
  assign unused_bits  = ^{pc_i[1:0], flush_pc_i[OFF-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (redirect)  rd_ptr <= wr_ptr;
      else if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_idx]  <= req_tag;
      data_mem[wr_idx] <= r_data_i;
      err_mem[wr_idx]  <= |r_resp_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      drop       <= 1'b0;
      fetch_tag  <= RESET_PC[31:OFF];
      ar_valid_o <= 1'b0;
      ar_addr_o  <= '0;
      r_ready_o  <= 1'b0;
    end else begin
      if (redirect) fetch_tag <= target_tag;
      case (state)
        S_IDLE: begin
          if (!redirect && (count < (PW+1)'(DEPTH))) begin
            state      <= S_AR;
            ar_valid_o <= 1'b1;
            ar_addr_o  <= {fetch_tag, {OFF{1'b0}}};
          end
        end
        S_AR: begin
          // The address phase is never retracted; its response is marked for discard instead.
          if (redirect) drop <= 1'b1;
          if (ar_ready_i) begin
            state      <= S_R;
            ar_valid_o <= 1'b0;
            r_ready_o  <= 1'b1;
            if (!redirect) fetch_tag <= fetch_tag + TAG_W'(1);
          end
        end
        S_R: begin
          if (r_valid_i) begin
            drop      <= 1'b0;
            state     <= S_IDLE;
            r_ready_o <= 1'b0;
          end else if (redirect) begin
            drop <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          ar_valid_o <= 1'b0;
          r_ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050019_prefetch_buffer.sv
// tb_ysyx_22050019_prefetch_buffer: directed scenarios plus a randomized run against a queue-level model.
`default_nettype none

module tb_ysyx_22050019_prefetch_buffer;
  localparam int LINE_W = 128;
  localparam int DEPTH  = 4;
  localparam int OFF    = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ar_ready_i;
  logic              ar_valid_o;
  logic [31:0]       ar_addr_o;
  logic              r_valid_i;
  logic [LINE_W-1:0] r_data_i;
  logic [1:0]        r_resp_i;
  logic              r_ready_o;
  logic              flush_i;
  logic [31:0]       flush_pc_i;
  logic [31:0]       pc_i;
  logic              inst_valid_o;
  logic [31:0]       inst_o;
  logic              inst_err_o;

  int checks = 0;
  int errors = 0;

  // Memory-slave state
  bit          s_pend;
  logic [31:0] s_addr;
  int          s_wait;
  bit          rand_mode;
  bit          rand_err;
  logic [31:0] err_line;

  always #5 clk = ~clk;

  ysyx_22050019_prefetch_buffer #(.LINE_W(LINE_W), .DEPTH(DEPTH), .RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .ar_ready_i(ar_ready_i), .ar_valid_o(ar_valid_o), .ar_addr_o(ar_addr_o),
    .r_valid_i(r_valid_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_ready_o(r_ready_o),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i), .pc_i(pc_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_err_o(inst_err_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    logic [31:0] base;
    base = {a[31:OFF], {OFF{1'b0}}};
    l = '0;
    for (int k = 0; k < LINE_W / 32; k++) l[k*32 +: 32] = mem_word(base + 32'(4 * k));
    return l;
  endfunction

  function automatic bit err_of(input logic [31:0] a);
    logic [31:0] line;
    line = {a[31:OFF], {OFF{1'b0}}};
    return (line == err_line) || (rand_err && line[6:4] == 3'd5);
  endfunction

  // One clock: sample handshakes, advance, then drive the slave's R channel at the falling edge.
  task automatic tick();
    bit hs, bt;
    logic [31:0] a;
    hs = ar_valid_o && ar_ready_i;
    bt = r_valid_i && r_ready_o;
    a  = ar_addr_o;
    @(posedge clk);
    @(negedge clk);
    if (bt) s_pend = 1'b0;
    if (hs) begin
      s_pend = 1'b1;
      s_addr = a;
      s_wait = rand_mode ? int'($urandom_range(0, 2)) : 0;
    end else if (s_pend && s_wait > 0) begin
      s_wait--;
    end
    r_valid_i = s_pend && (s_wait == 0);
    r_data_i  = s_pend ? mem_line(s_addr) : '0;
    r_resp_i  = (s_pend && err_of(s_addr)) ? 2'b10 : 2'b00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush_i = 1'b0; flush_pc_i = '0; ar_ready_i = 1'b0; pc_i = 32'h8000_0000;
    s_pend = 1'b0; s_wait = 0;
    r_valid_i = 1'b0; r_data_i = '0; r_resp_i = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rand_mode = 1'b0; rand_err = 1'b0; err_line = 32'h1;
    rst_n = 1'b0;
    flush_i = 1'b0; flush_pc_i = '0; ar_ready_i = 1'b1; pc_i = 32'h8000_0000;
    r_valid_i = 1'b0; r_data_i = '0; r_resp_i = 2'b00;
    @(negedge clk);
    #1;
    checks++;
    if (ar_valid_o !== 1'b0) begin errors++; $display("FAIL reset_ar_valid got %b exp 0", ar_valid_o); end
    checks++;
    if (r_ready_o !== 1'b0) begin errors++; $display("FAIL reset_r_ready got %b exp 0", r_ready_o); end
    checks++;
    if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid_o); end
    do_reset();
  endtask

  task automatic test_fill();
    int n;
    bit first;
    n = 0; first = 1'b1;
    ar_ready_i = 1'b1; pc_i = 32'h8000_0000;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (first && r_valid_i && r_ready_o) begin
        first = 1'b0;
        checks++;
        if (inst_valid_o !== 1'b1 || inst_o !== mem_word(pc_i)) begin
          errors++;
          $display("FAIL fill_bypass got v=%b i=%h exp v=1 i=%h", inst_valid_o, inst_o, mem_word(pc_i));
        end
      end
      if (ar_valid_o && ar_ready_i) begin
        checks++;
        if (n >= 4 || ar_addr_o !== 32'h8000_0000 + 32'(16 * n)) begin
          errors++;
          $display("FAIL fill_req%0d got %h exp %h", n, ar_addr_o, 32'h8000_0000 + 32'(16 * n));
        end
        n++;
      end
      tick();
    end
    #1;
    checks++;
    if (first) begin errors++; $display("FAIL fill_bypass_seen got 0 exp 1"); end
    checks++;
    if (n != 4) begin errors++; $display("FAIL fill_req_count got %0d exp 4", n); end
    checks++;
    if (ar_valid_o !== 1'b0) begin errors++; $display("FAIL fill_full_idle got %b exp 0", ar_valid_o); end
  endtask

  task automatic test_sequential();
    bit found;
    logic [31:0] a;
    pc_i = 32'h8000_000C; #1;
    checks++;
    if (inst_valid_o !== 1'b1 || inst_o !== mem_word(32'h8000_000C)) begin
      errors++; $display("FAIL seq_word3 got v=%b i=%h exp v=1 i=%h", inst_valid_o, inst_o, mem_word(32'h8000_000C));
    end
    tick();
    pc_i = 32'h8000_0010; #1;
    checks++;
    if (inst_valid_o !== 1'b1 || inst_o !== mem_word(32'h8000_0010)) begin
      errors++; $display("FAIL seq_advance got v=%b i=%h exp v=1 i=%h", inst_valid_o, inst_o, mem_word(32'h8000_0010));
    end
    checks++;
    if (ar_valid_o !== 1'b0) begin errors++; $display("FAIL seq_no_req_full got %b exp 0", ar_valid_o); end
    tick();
    #1;
    checks++;
    if (inst_valid_o !== 1'b1 || inst_o !== mem_word(32'h8000_0010)) begin
      errors++; $display("FAIL seq_after_pop got v=%b i=%h exp v=1 i=%h", inst_valid_o, inst_o, mem_word(32'h8000_0010));
    end
    found = 1'b0; a = '0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (ar_valid_o && ar_ready_i) begin found = 1'b1; a = ar_addr_o; end
      tick();
    end
    checks++;
    if (!found || a !== 32'h8000_0040) begin errors++; $display("FAIL seq_refill_addr got %h found=%b exp 80000040", a, found); end
  endtask

  task automatic test_flush_in_r();
    bit found;
    logic [31:0] a;
    #1;
    checks++;
    if (r_ready_o !== 1'b1 || r_valid_i !== 1'b1) begin
      errors++; $display("FAIL flush_in_r_state got r_ready=%b exp 1", r_ready_o);
    end
    flush_i = 1'b1; flush_pc_i = 32'h8000_1004; #1;
    checks++;
    if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL flush_cycle_valid got %b exp 0", inst_valid_o); end
    tick();
    flush_i = 1'b0; pc_i = 32'h8000_1004; #1;
    checks++;
    if (inst_valid_o !== 1'b0 || r_ready_o !== 1'b0) begin
      errors++; $display("FAIL flush_empty got v=%b rr=%b exp 0 0", inst_valid_o, r_ready_o);
    end
    found = 1'b0; a = '0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (ar_valid_o && ar_ready_i) begin found = 1'b1; a = ar_addr_o; end
      tick();
    end
    checks++;
    if (!found || a !== 32'h8000_1000) begin errors++; $display("FAIL flush_target_addr got %h exp 80001000", a); end
    #1;
    checks++;
    if (inst_valid_o !== 1'b1 || inst_o !== mem_word(32'h8000_1004)) begin
      errors++; $display("FAIL flush_target_word got v=%b i=%h exp v=1 i=%h", inst_valid_o, inst_o, mem_word(32'h8000_1004));
    end
  endtask

  task automatic test_implicit_redirect();
    bit found, was_ar;
    int seen;
    logic [31:0] a;
    for (int c = 0; c < 6; c++) tick();
    pc_i = 32'h8000_2008; #1;
    checks++;
    if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL miss_valid got %b exp 0", inst_valid_o); end
    was_ar = ar_valid_o;
    tick();
    found = 1'b0; a = '0; seen = 0;
    for (int c = 0; c < 15 && !found; c++) begin
      #1;
      if (ar_valid_o && ar_ready_i) begin
        if (was_ar && seen == 0) seen = 1;
        else begin found = 1'b1; a = ar_addr_o; end
      end
      tick();
    end
    checks++;
    if (!found || a !== 32'h8000_2000) begin errors++; $display("FAIL miss_target_addr got %h exp 80002000", a); end
    #1;
    checks++;
    if (inst_valid_o !== 1'b1 || inst_o !== mem_word(32'h8000_2008)) begin
      errors++; $display("FAIL miss_target_word got v=%b i=%h exp v=1 i=%h", inst_valid_o, inst_o, mem_word(32'h8000_2008));
    end
  endtask

  task automatic test_error_line();
    err_line = 32'h8000_0010;
    flush_i = 1'b1; flush_pc_i = 32'h8000_0000;
    tick();
    flush_i = 1'b0; pc_i = 32'h8000_0000;
    for (int c = 0; c < 15; c++) tick();
    #1;
    checks++;
    if (inst_valid_o !== 1'b1 || inst_err_o !== 1'b0) begin
      errors++; $display("FAIL err_good_line got v=%b e=%b exp 1 0", inst_valid_o, inst_err_o);
    end
    pc_i = 32'h8000_0014; #1;
    checks++;
    if (inst_valid_o !== 1'b1 || inst_err_o !== 1'b1 || inst_o !== mem_word(32'h8000_0014)) begin
      errors++; $display("FAIL err_bad_line got v=%b e=%b i=%h exp 1 1 %h", inst_valid_o, inst_err_o, inst_o, mem_word(32'h8000_0014));
    end
    tick();
    err_line = 32'h1;
  endtask

  task automatic test_reset_mid_wait();
    bit found;
    logic [31:0] a, held;
    ar_ready_i = 1'b0; pc_i = 32'h8000_0010;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (ar_valid_o) found = 1'b1;
      else tick();
    end
    held = ar_addr_o;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        #2; rst_n = 1'b0;
        s_pend = 1'b0; r_valid_i = 1'b0;
        #1;
        checks++;
        if (ar_valid_o !== 1'b0 || inst_valid_o !== 1'b0) begin
          errors++; $display("FAIL async_reset got arv=%b v=%b exp 0 0", ar_valid_o, inst_valid_o);
        end
      end else if (c < 2) begin
        #1;
        checks++;
        if (!found || ar_valid_o !== 1'b1 || ar_addr_o !== held) begin
          errors++; $display("FAIL ar_hold got arv=%b addr=%h exp 1 %h", ar_valid_o, ar_addr_o, held);
        end
      end
      tick();
    end
    rst_n = 1'b1; ar_ready_i = 1'b1; pc_i = 32'h8000_0000;
    found = 1'b0; a = '0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (ar_valid_o && ar_ready_i) begin found = 1'b1; a = ar_addr_o; end
      tick();
    end
    checks++;
    if (!found || a !== 32'h8000_0000) begin errors++; $display("FAIL post_reset_addr got %h exp 80000000", a); end
  endtask

  // Model: FIFO as a queue of line tags, plus the single outstanding request (none / address / data).
  task automatic test_random();
    logic [27:0] q_tag[$];
    bit          q_err[$];
    logic [27:0] m_next, m_ptag, ptag;
    int          m_pend, hidx, sz, old_pend, r;
    bit          m_drop, miss, redir, beat, byp, ev, eerr, last_valid, prev_flush;
    logic [31:0] prev_fpc;

    do_reset();
    rand_mode = 1'b1; rand_err = 1'b1; err_line = 32'h1;
    m_next = 28'h800_0000; m_ptag = '0; m_pend = 0; m_drop = 1'b0;
    last_valid = 1'b0; prev_flush = 1'b0; prev_fpc = '0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (prev_flush) pc_i = prev_fpc;
      ar_ready_i = ($urandom % 4) != 0;
      flush_i = 1'b0;
      r = int'($urandom % 100);
      if (r < 3) begin
        flush_i = 1'b1;
        if ($urandom % 8 == 0) flush_pc_i = 32'hFFFF_FFC0 + 32'(($urandom % 16) * 4);
        else flush_pc_i = 32'h8000_0000 + 32'(($urandom % 64) * 4);
      end else if (r < 6) begin
        pc_i = 32'h8000_0000 + 32'(($urandom % 64) * 4);
      end else if (last_valid && r < 70) begin
        pc_i = pc_i + 32'd4;
      end
      #1;
      ptag = pc_i[31:OFF];
      sz = q_tag.size();
      hidx = -1;
      if (sz > 0 && q_tag[0] == ptag) hidx = 0;
      else if (sz > 1 && q_tag[1] == ptag) hidx = 1;
      miss  = (sz > 0) && (hidx < 0);
      redir = flush_i || miss;
      beat  = (m_pend == 2) && r_valid_i;
      byp   = (sz == 0) && beat && !m_drop && (m_ptag == ptag) && !flush_i;
      ev    = !flush_i && (hidx >= 0 || byp);
      eerr  = byp ? (r_resp_i != 2'b00) : ((hidx >= 0) ? q_err[hidx] : 1'b0);

      checks++;
      if (ar_valid_o !== (m_pend == 1)) begin
        errors++; $display("FAIL rnd_ar_valid cyc %0d got %b exp %b", cyc, ar_valid_o, (m_pend == 1));
      end
      if (m_pend == 1) begin
        checks++;
        if (ar_addr_o !== {m_ptag, 4'h0}) begin
          errors++; $display("FAIL rnd_ar_addr cyc %0d got %h exp %h", cyc, ar_addr_o, {m_ptag, 4'h0});
        end
      end
      checks++;
      if (r_ready_o !== (m_pend == 2)) begin
        errors++; $display("FAIL rnd_r_ready cyc %0d got %b exp %b", cyc, r_ready_o, (m_pend == 2));
      end
      checks++;
      if (inst_valid_o !== ev) begin
        errors++; $display("FAIL rnd_inst_valid cyc %0d pc %h got %b exp %b", cyc, pc_i, inst_valid_o, ev);
      end
      if (ev) begin
        checks++;
        if (inst_o !== mem_word(pc_i) || inst_err_o !== eerr) begin
          errors++; $display("FAIL rnd_inst cyc %0d pc %h got %h/%b exp %h/%b", cyc, pc_i, inst_o, inst_err_o, mem_word(pc_i), eerr);
        end
      end
      last_valid = ev;

      old_pend = m_pend;
      if (redir) begin
        q_tag.delete(); q_err.delete();
        m_next = flush_i ? flush_pc_i[31:OFF] : ptag;
      end else if (hidx == 1) begin
        void'(q_tag.pop_front()); void'(q_err.pop_front());
      end
      if (old_pend == 0) begin
        if (!redir && sz < DEPTH) begin m_pend = 1; m_ptag = m_next; end
      end else if (old_pend == 1) begin
        if (redir) m_drop = 1'b1;
        if (ar_ready_i) begin
          m_pend = 2;
          if (!redir) m_next = m_next + 28'd1;
        end
      end else begin
        if (beat) begin
          if (!redir && !m_drop) begin q_tag.push_back(m_ptag); q_err.push_back(r_resp_i != 2'b00); end
          m_drop = 1'b0;
          m_pend = 0;
        end else if (redir) begin
          m_drop = 1'b1;
        end
      end
      prev_flush = flush_i;
      prev_fpc = flush_pc_i;
      tick();
    end
    flush_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_sequential();
    test_flush_in_r();
    test_implicit_redirect();
    test_error_line();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ysyx_22050019_prefetch_buffer.md
Name: ysyx_22050019_prefetch_buffer

Overview:
- Parametrised instruction prefetch buffer between IFU and I-cache AXI-lite read port.
- Holds up to DEPTH tagged cache lines in a FIFO and prefetches sequential lines ahead of pc_i.
- Serves 32-bit instructions combinationally on a hit and discards stale lines and in-flight responses on redirect.
- Forwards bus errors per line.

Parameters:
- LINE_W, 128: cache-line width in bits; power of 2, at least 64.
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- RESET_PC, 32'h80000000: first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ar_ready_i  in  1  I-cache address ready.
- ar_valid_o  out  1  address valid.
- ar_addr_o  out  32  line-aligned request address.
- r_valid_i  in  1  read data valid.
- r_data_i  in  LINE_W  line data.
- r_resp_i  in  2  response; nonzero means error.
- r_ready_o  out  1  read data ready.
- flush_i  in  1  redirect from branch/jump/exception.
- flush_pc_i  in  32  redirect target.
- pc_i  in  32  current IFU pc, word aligned.
- inst_valid_o  out  1  inst_o/inst_err_o valid this cycle.
- inst_o  out  32  instruction at pc_i.
- inst_err_o  out  1  line holding pc_i returned an error response.

Behaviour:
- OFF = log2(LINE_W/8); tag = pc[31:OFF]. Each entry stores {tag, data, err}. Pointers are log2(DEPTH)+1 bits with a wrap bit.
- Full: pointers equal except the wrap bit. Empty: pointers equal.
- Reset (async) values:
  - Pointers cleared; state IDLE; drop flag 0.
  - fetch_tag = RESET_PC[31:OFF].
  - ar_valid_o = 0, r_ready_o = 0, inst_valid_o = 0.
- Hit: head valid and head tag == pc_i tag.
  - inst_valid_o = 1; inst_o = head data word pc_i[OFF-1:2]; inst_err_o = head err.
- Sequential advance: non-empty, head tag != pc_i tag, and second entry tag == pc_i tag.
  - Pop head this cycle; the hit is served from the second entry in the same cycle.
- Miss: non-empty, and pc_i tag matches neither the head nor the second entry.
  - Treated as an implicit redirect to pc_i, identical to flush_i with flush_pc_i = pc_i.
- Bypass: FIFO empty, R beat accepted, drop flag 0, and beat tag == pc_i tag.
  - inst_valid_o = 1 in the same cycle with r_data_i/r_resp_i; the beat is also written to the FIFO.
- Otherwise inst_valid_o = 0.
- Request FSM:
  - IDLE -> AR when count + (state != IDLE) < DEPTH and no flush this cycle.
  - AR: ar_valid_o = 1, ar_addr_o = {fetch_tag, OFF zeros}. Address and valid are held stable until ar_ready_i.
  - AR -> R on ar_valid_o & ar_ready_i; fetch_tag increments by 1, wrapping modulo 2^(32-OFF).
  - R: r_ready_o = 1. On r_valid_i, push {tag, data, r_resp_i != 0} unless the drop flag is set, clear drop, -> IDLE.
  - Only one outstanding request at a time.
- Flush (flush_i or implicit miss):
  - Empty the FIFO (rd_ptr <= wr_ptr) and set fetch_tag = target tag.
  - In AR state: the handshake still completes (valid is not retracted); the flag is set to drop the coming response.
  - In R state: set drop unless the beat completes in the same cycle, in which case that beat is discarded directly.
  - inst_valid_o = 0 in the flush cycle.
  - flush_i has priority over hit, advance and push.
- Simultaneous push and pop keep count unchanged. A push never occurs when full, because the FIFO never reaches full with a request outstanding.
- Error lines are served normally with inst_err_o = 1. They are not retried.

Test Plan:
- Reset, ar_ready_i = 1, 1-cycle R latency, pc_i = 0x80000000 -> requests 0x80000000, 0x80000010, 0x80000020, 0x80000030, then ar_valid_o stays low (full); inst_valid_o = 1 on the first beat via bypass.
- Sequential step pc_i 0x80000000 -> 0x8000000C -> 0x80000010 -> one pop at 0x80000010, followed by new request 0x80000040; inst_o selects words 0, 3, then 0 of the next line.
- flush_i with flush_pc_i = 0x80001004 while in R state -> in-flight beat consumed and discarded, FIFO empty, next ar_addr_o = 0x80001000, inst_o = word 1 of that line.
- pc_i jumps to 0x80002008 without flush_i -> implicit redirect, next ar_addr_o = 0x80002000.
- r_resp_i = 2'b10 on line 0x80000010 -> when pc_i = 0x80000014: inst_valid_o = 1, inst_err_o = 1.
- ar_ready_i held low for 5 cycles with an async reset pulse mid-wait -> ar_valid_o drops immediately; after release the first request is 0x80000000.
